// File: rtl/ex_muldiv_unit_if.sv
// Handshake bundle between the ID/EX register, the RV32M iterative unit and the hazard unit.
// The master side is the ID/EX stage; the slave side is the multiply/divide unit.
interface ex_muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start_i;
   logic            kill_i;
   logic [9:0]      funct_i;
   logic [XLEN-1:0] RS1data_i;
   logic [XLEN-1:0] RS2data_i;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output start_i, kill_i, funct_i, RS1data_i, RS2data_i,
      input  busy_o, done_o, result_o
   );

   modport slave (
      input  start_i, kill_i, funct_i, RS1data_i, RS2data_i,
      output busy_o, done_o, result_o
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// RV32M EX-stage unit: shift-add multiply and restoring divide, one bit per cycle.
// Fixed latency: XLEN iteration cycles, one sign/special-case fix-up cycle, one done cycle.
module ex_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   ex_muldiv_unit_if.slave   bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   counter;
   logic            busy_r;
   logic            done_r;
   logic [XLEN-1:0] result_r;

   logic [2:0]      op;
   logic            neg_q;
   logic            neg_r;
   logic            b_zero;
   logic [XLEN-1:0] a_raw;
   logic [XLEN-1:0] mc;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
      return ~v + 1'b1;
   endfunction

   function automatic logic [2*XLEN-1:0] negate_wide(input logic [2*XLEN-1:0] v);
      return ~v + 1'b1;
   endfunction

   logic                   accept;
   logic [2:0]             f3;
   logic                   is_div;
   logic                   a_signed;
   logic                   b_signed;
   logic signed [XLEN-1:0] rs1_s;
   logic signed [XLEN-1:0] rs2_s;
   logic                   sa;
   logic                   sb;
   logic [XLEN-1:0]        a_mag;
   logic [XLEN-1:0]        b_mag;

   assign accept   = bus.start_i && (bus.funct_i[9:3] == 7'b0000001) &&
                     ((state == IDLE) || (state == DONE)) && !bus.kill_i;
   assign f3       = bus.funct_i[2:0];
   assign is_div   = f3[2];
   assign a_signed = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
   assign b_signed = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
   assign rs1_s    = bus.RS1data_i;
   assign rs2_s    = bus.RS2data_i;
   assign sa       = a_signed && (rs1_s < 0);
   assign sb       = b_signed && (rs2_s < 0);
   assign a_mag    = sa ? negate(bus.RS1data_i) : bus.RS1data_i;
   assign b_mag    = sb ? negate(bus.RS2data_i) : bus.RS2data_i;

   // One iteration step: multiply adds the multiplicand and shifts right,
   // divide shifts left one dividend bit into the partial remainder and trial-subtracts.
   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] trial;

   assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, mc} : {(XLEN+1){1'b0}});
   assign shifted = {hi, lo[XLEN-1]};
   assign trial   = shifted - {1'b0, mc};

   always_ff @(posedge clk_i) begin
      if (accept) begin
         op     <= f3;
         a_raw  <= bus.RS1data_i;
         b_zero <= (bus.RS2data_i == '0);
         neg_q  <= sa ^ sb;
         neg_r  <= sa;
         hi     <= '0;
         mc     <= is_div ? b_mag : a_mag;
         lo     <= is_div ? a_mag : b_mag;
      end else if (state == ITER) begin
         if (op[2]) begin
            hi <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
            lo <= {lo[XLEN-2:0], ~trial[XLEN]};
         end else begin
            hi <= sum[XLEN:1];
            lo <= {sum[0], lo[XLEN-1:1]};
         end
      end
   end

   // Sign fix-up and special cases. The signed-overflow divide falls out of the
   // magnitude path naturally: |0x80000000| / 1 gives 0x80000000 with remainder 0.
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;
   logic [XLEN-1:0]   final_res;

   always_comb begin
      prod_fix  = neg_q ? negate_wide({hi, lo}) : {hi, lo};
      quo_fix   = neg_q ? negate(lo) : lo;
      rem_fix   = neg_r ? negate(hi) : hi;
      final_res = '0;
      case (op)
         3'b000:                 final_res = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         final_res = b_zero ? '1 : quo_fix;
         default:                final_res = b_zero ? a_raw : rem_fix;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         counter  <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state   <= ITER;
                  counter <= '0;
                  busy_r  <= 1'b1;
               end
            end
            ITER: begin
               if (bus.kill_i) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end else if (counter == CW'(XLEN-1)) begin
                  state <= FIX;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            FIX: begin
               state  <= bus.kill_i ? IDLE : DONE;
               busy_r <= 1'b0;
               if (!bus.kill_i) begin
                  done_r   <= 1'b1;
                  result_r <= final_res;
               end
            end
            default: begin
               if (accept) begin
                  state   <= ITER;
                  counter <= '0;
                  busy_r  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.busy_o   = busy_r;
   assign bus.done_o   = done_r;
   assign bus.result_o = result_r;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for the RV32M iterative unit: results, latency, kill, reset and back-to-back starts.
module tb_ex_muldiv_unit;
   localparam int XLEN = 32;
   localparam logic [6:0] M7 = 7'b0000001;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   ex_muldiv_unit_if #(.XLEN(XLEN)) bus ();

   ex_muldiv_unit #(.XLEN(XLEN)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the first negedge after the accept edge (sample 1).
   task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      bus.start_i   = 1'b1;
      bus.funct_i   = {M7, f3};
      bus.RS1data_i = a;
      bus.RS2data_i = b;
      @(posedge clk);
      @(negedge clk);
      bus.start_i = 1'b0;
   endtask

   task automatic wait_done(output int idx);
      idx = 0;
      for (int i = 1; i <= 60; i++) begin
         if (bus.done_o) begin
            idx = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      int idx;
      start_op(f3, a, b);
      wait_done(idx);
      check({tag, "_lat"}, idx, 34);
      check(tag, bus.result_o, exp);
      @(negedge clk);
   endtask

   initial begin
      int busy_cnt;
      int done_cnt;
      int done_idx;
      int idx;

      rst_n         = 1'b0;
      bus.start_i   = 1'b0;
      bus.kill_i    = 1'b0;
      bus.funct_i   = '0;
      bus.RS1data_i = '0;
      bus.RS2data_i = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy_o, 0);
      check("rst_done", bus.done_o, 0);
      check("rst_result", bus.result_o, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // MUL with timing profile; a start pulse while busy must be ignored
      start_op(3'b000, 32'd7, 32'hFFFF_FFFD);
      busy_cnt = 0;
      done_cnt = 0;
      done_idx = 0;
      for (int n = 1; n <= 40; n++) begin
         if (bus.busy_o) busy_cnt++;
         if (bus.done_o) begin
            done_cnt++;
            if (done_idx == 0) done_idx = n;
         end
         if (n == 5) begin
            bus.start_i   = 1'b1;
            bus.funct_i   = {M7, 3'b101};
            bus.RS1data_i = 32'd1;
            bus.RS2data_i = 32'd1;
         end
         if (n == 6) bus.start_i = 1'b0;
         @(negedge clk);
      end
      check("mul_busy_cycles", busy_cnt, 33);
      check("mul_done_index", done_idx, 34);
      check("mul_done_count", done_cnt, 1);
      check("mul", bus.result_o, 32'hFFFF_FFEB);

      // Non-M funct7 must not start anything
      bus.start_i = 1'b1;
      bus.funct_i = {7'b0100000, 3'b000};
      @(negedge clk);
      bus.start_i = 1'b0;
      check("nonm_busy", bus.busy_o, 0);
      @(negedge clk);
      check("nonm_busy2", bus.busy_o, 0);

      run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run_op("divu",   3'b101, 32'd100, 32'd7, 32'd14);
      run_op("div_z",  3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
      run_op("remu_z", 3'b111, 32'd5, 32'd0, 32'd5);
      run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      run_op("remu",   3'b111, 32'd100, 32'd7, 32'd2);

      // Kill at ITER counter 10, then a fresh start right after
      start_op(3'b000, 32'd3, 32'd3);
      repeat (10) @(negedge clk);
      bus.kill_i = 1'b1;
      @(negedge clk);
      bus.kill_i = 1'b0;
      check("kill_busy", bus.busy_o, 0);
      check("kill_done", bus.done_o, 0);
      check("kill_result", bus.result_o, 32'd2);
      start_op(3'b101, 32'd100, 32'd7);
      check("post_kill_busy", bus.busy_o, 1);
      wait_done(idx);
      check("post_kill_lat", idx, 34);
      check("post_kill_divu", bus.result_o, 32'd14);
      @(negedge clk);

      // Reset in the middle of an operation
      start_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", bus.busy_o, 0);
      check("midrst_done", bus.done_o, 0);
      check("midrst_result", bus.result_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      busy_cnt = 0;
      done_cnt = 0;
      for (int n = 0; n < 40; n++) begin
         if (bus.busy_o) busy_cnt++;
         if (bus.done_o) done_cnt++;
         @(negedge clk);
      end
      check("midrst_no_busy", busy_cnt, 0);
      check("midrst_no_done", done_cnt, 0);

      // Back-to-back: start presented while in DONE
      start_op(3'b101, 32'd100, 32'd7);
      wait_done(idx);
      check("b2b_first_lat", idx, 34);
      check("b2b_first", bus.result_o, 32'd14);
      start_op(3'b111, 32'd100, 32'd7);
      check("b2b_busy", bus.busy_o, 1);
      check("b2b_done_low", bus.done_o, 0);
      wait_done(idx);
      check("b2b_second_lat", idx, 34);
      check("b2b_second", bus.result_o, 32'd2);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
